// File: rtl/mesh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mesh_pkg
// Description : Shared flit layout, field extractors and injection FSM
//               encoding for the 2x2 mesh network interface.
// Revision    : 1.0 - initial release
// ============================================================================
package mesh_pkg;

    localparam int FLIT_LENGTH = 72;

    // Field positions inside a flit
    localparam int c_TYPE_LSB  = 70;
    localparam int c_TYPE_W    = 2;
    localparam int c_COORD_W   = 3;
    localparam int c_SX_LSB    = 67;
    localparam int c_SY_LSB    = 64;
    localparam int c_DX_LSB    = 61;
    localparam int c_DY_LSB    = 58;
    localparam int c_TIME_LSB  = 16;
    localparam int c_TIME_W    = 42;
    localparam int c_NUM_LSB   = 0;
    localparam int c_NUM_W     = 16;

    // Injection state machine encoding
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_REQ  = 1'b1;

    function automatic logic [c_TYPE_W-1:0] flit_type(input logic [FLIT_LENGTH-1:0] f);
        return f[c_TYPE_LSB +: c_TYPE_W];
    endfunction

    function automatic logic [c_COORD_W-1:0] flit_src_x(input logic [FLIT_LENGTH-1:0] f);
        return f[c_SX_LSB +: c_COORD_W];
    endfunction

    function automatic logic [c_COORD_W-1:0] flit_src_y(input logic [FLIT_LENGTH-1:0] f);
        return f[c_SY_LSB +: c_COORD_W];
    endfunction

    function automatic logic [c_COORD_W-1:0] flit_dst_x(input logic [FLIT_LENGTH-1:0] f);
        return f[c_DX_LSB +: c_COORD_W];
    endfunction

    function automatic logic [c_COORD_W-1:0] flit_dst_y(input logic [FLIT_LENGTH-1:0] f);
        return f[c_DY_LSB +: c_COORD_W];
    endfunction

    function automatic logic [c_TIME_W-1:0] flit_time(input logic [FLIT_LENGTH-1:0] f);
        return f[c_TIME_LSB +: c_TIME_W];
    endfunction

    function automatic logic [c_NUM_W-1:0] flit_num(input logic [FLIT_LENGTH-1:0] f);
        return f[c_NUM_LSB +: c_NUM_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_ni_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mesh_ni_fifo
// Description : Synchronous FIFO for the injection path. Exposes the head
//               entry and the entry behind it so the injector can chain
//               back-to-back transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_ni_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 72
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH_CNT = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    // A push while full is dropped even if a pop frees a slot this cycle
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    assign full      = (r_count == c_DEPTH_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign head_next = r_mem[r_rd_ptr + c_PTR_ONE];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mesh_ni.sv
`default_nettype none
// ============================================================================
// Module      : mesh_ni
// Description : Mesh node network interface. Injects time-released host
//               flits into the router local port and ejects router flits
//               to the host, tracking received flit numbers and misroutes.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_ni
    import mesh_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             lx,
    input  logic [2:0]             ly,
    input  logic                   tx_wr,
    input  logic [FLIT_LENGTH-1:0] tx_flit,
    output logic                   tx_full,
    output logic                   reqin,
    input  logic                   ackin,
    output logic [FLIT_LENGTH-1:0] datain,
    input  logic                   reqout,
    input  logic [FLIT_LENGTH-1:0] dataout,
    output logic                   ackout,
    output logic                   rx_valid,
    output logic [FLIT_LENGTH-1:0] rx_flit,
    input  logic                   rx_ready,
    output logic [63:0]            rx_seen,
    output logic [c_TIME_W-1:0]    cyc,
    output logic                   err_overflow,
    output logic                   err_misroute
);

    localparam int                 c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_TWO   = c_CNT_W'(2);

    logic [c_TIME_W-1:0]    r_cyc;
    logic                   w_push_req;
    logic                   w_full;
    logic                   w_empty;
    logic [FLIT_LENGTH-1:0] w_head;
    logic [FLIT_LENGTH-1:0] w_head_next;
    logic [c_CNT_W-1:0]     w_count;
    logic                   w_head_due;
    logic                   w_next_due;
    logic                   w_pop;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   r_err_overflow;
    logic                   r_rx_valid;
    logic [FLIT_LENGTH-1:0] r_rx_flit;
    logic [63:0]            r_rx_seen;
    logic                   r_err_misroute;
    logic                   w_capture;

    // Free-running cycle counter that sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc <= '0;
        end else if (r_cyc != '1) begin
            r_cyc <= r_cyc + c_TIME_W'(1);
        end
    end

    // An all-zero flit is the end marker and never enters the queue
    assign w_push_req = tx_wr && (tx_flit != '0);

    mesh_ni_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_LENGTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push_req),
        .push_data (tx_flit),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head),
        .head_next (w_head_next),
        .count     (w_count)
    );

    // Sticky overflow flag for pushes rejected by a full queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_overflow <= 1'b0;
        end else if (w_push_req && w_full) begin
            r_err_overflow <= 1'b1;
        end
    end

    assign w_head_due = !w_empty && (flit_time(w_head) <= r_cyc);
    assign w_next_due = (w_count >= c_TWO) && (flit_time(w_head_next) <= r_cyc);

    // Injection state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Injection next-state and outputs; datain tracks the FIFO head, which only moves on a transfer
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        reqin       = 1'b0;
        datain      = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_head_due) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                reqin  = 1'b1;
                datain = w_head;
                if (ackin) begin
                    w_pop = 1'b1;
                    if (!w_next_due) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Ejection accepts whenever the host-side holding register is free or being drained
    assign ackout    = reqout && (!r_rx_valid || rx_ready);
    assign w_capture = reqout && ackout;

    // Ejection capture, host handoff and receive bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid     <= 1'b0;
            r_rx_flit      <= '0;
            r_rx_seen      <= '0;
            r_err_misroute <= 1'b0;
        end else if (w_capture) begin
            r_rx_flit                 <= dataout;
            r_rx_valid                <= 1'b1;
            r_rx_seen[dataout[5:0]]   <= 1'b1;
            if ((flit_dst_x(dataout) != lx) || (flit_dst_y(dataout) != ly)) begin
                r_err_misroute <= 1'b1;
            end
        end else if (rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign tx_full      = w_full;
    assign cyc          = r_cyc;
    assign err_overflow = r_err_overflow;
    assign rx_valid     = r_rx_valid;
    assign rx_flit      = r_rx_flit;
    assign rx_seen      = r_rx_seen;
    assign err_misroute = r_err_misroute;

endmodule
`default_nettype wire

// File: tb/tb_mesh_ni.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_ni
// Description : Scoreboard bench for mesh_ni. Directed stimulus pushes the
//               expected injected/ejected flits into queues; a negedge
//               monitor pops and compares on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_ni;
    import mesh_pkg::*;

    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [2:0]             lx, ly;
    logic                   tx_wr;
    logic [FLIT_LENGTH-1:0] tx_flit;
    logic                   tx_full;
    logic                   reqin;
    logic                   ackin;
    logic [FLIT_LENGTH-1:0] datain;
    logic                   reqout;
    logic [FLIT_LENGTH-1:0] dataout;
    logic                   ackout;
    logic                   rx_valid;
    logic [FLIT_LENGTH-1:0] rx_flit;
    logic                   rx_ready;
    logic [63:0]            rx_seen;
    logic [41:0]            cyc;
    logic                   err_overflow;
    logic                   err_misroute;

    int checks   = 0;
    int failures = 0;

    logic [FLIT_LENGTH-1:0] inj_q[$];
    logic [FLIT_LENGTH-1:0] rx_q[$];
    logic [FLIT_LENGTH-1:0] m_exp;

    mesh_ni #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .lx           (lx),
        .ly           (ly),
        .tx_wr        (tx_wr),
        .tx_flit      (tx_flit),
        .tx_full      (tx_full),
        .reqin        (reqin),
        .ackin        (ackin),
        .datain       (datain),
        .reqout       (reqout),
        .dataout      (dataout),
        .ackout       (ackout),
        .rx_valid     (rx_valid),
        .rx_flit      (rx_flit),
        .rx_ready     (rx_ready),
        .rx_seen      (rx_seen),
        .cyc          (cyc),
        .err_overflow (err_overflow),
        .err_misroute (err_misroute)
    );

    always #5 clk = ~clk;

    // Flit builder: type=01, src=(0,0), given dst, release time and number
    function automatic logic [FLIT_LENGTH-1:0] mk(input logic [2:0] dx, input logic [2:0] dy,
                                                  input logic [41:0] t, input logic [15:0] num);
        return {2'b01, 3'd0, 3'd0, dx, dy, t, num};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flit(input logic [FLIT_LENGTH-1:0] f);
        tx_wr   = 1'b1;
        tx_flit = f;
        tick();
        tx_wr   = 1'b0;
        tx_flit = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_reqin"},    reqin, 0);
        chk({tag, "_datain"},   datain, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_rx_flit"},  rx_flit, 0);
        chk({tag, "_rx_seen"},  rx_seen, 0);
        chk({tag, "_cyc"},      cyc, 0);
        chk({tag, "_err_ovf"},  err_overflow, 0);
        chk({tag, "_err_mis"},  err_misroute, 0);
        chk({tag, "_tx_full"},  tx_full, 0);
    endtask

    // Scoreboard monitor: a handshake seen before a posedge is the transfer at that edge
    always @(negedge clk) begin
        if (!rst) begin
            if (reqin && ackin) begin
                checks++;
                if (inj_q.size() == 0) begin
                    failures++;
                    $display("FAIL inj_unexpected actual=%0h required=none", datain);
                end else begin
                    m_exp = inj_q.pop_front();
                    if (datain !== m_exp) begin
                        failures++;
                        $display("FAIL inj_data actual=%0h required=%0h", datain, m_exp);
                    end
                end
            end
            if (rx_valid && rx_ready) begin
                checks++;
                if (rx_q.size() == 0) begin
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h required=none", rx_flit);
                end else begin
                    m_exp = rx_q.pop_front();
                    if (rx_flit !== m_exp) begin
                        failures++;
                        $display("FAIL rx_data actual=%0h required=%0h", rx_flit, m_exp);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FLIT_LENGTH-1:0] f, f5, d7, d9, dm;
        logic [FLIT_LENGTH-1:0] fb[3];
        logic [63:0]            seen_exp;

        rst = 1'b1; lx = 3'd1; ly = 3'd0;
        tx_wr = 1'b0; tx_flit = '0; ackin = 1'b0;
        reqout = 1'b0; dataout = '0; rx_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_reset("rst0");
        chk("rst0_ackout", ackout, 0);

        // Single due flit: reqin rises after N+1, transfer at N+2
        ackin = 1'b1;
        f = mk(3'd1, 3'd0, 42'd0, 16'd1);
        inj_q.push_back(f);
        write_flit(f);
        chk("t1_reqin_N", reqin, 0);
        tick();
        chk("t1_reqin_N1", reqin, 1);
        chk("t1_datain_N1", datain, f);
        tick();
        chk("t1_reqin_N2", reqin, 0);
        chk("t1_datain_N2", datain, 0);

        // Timed release at 50
        do_reset();
        for (int i = 0; i < 20 && cyc < 42'd5; i++) tick();
        f = mk(3'd1, 3'd0, 42'd50, 16'd2);
        inj_q.push_back(f);
        write_flit(f);
        chk("t2_reqin_early", reqin, 0);
        for (int i = 0; i < 80 && !reqin; i++) tick();
        chk("t2_reqin_rise", reqin, 1);
        chk("t2_rise_cyc", cyc, 51);
        chk("t2_datain", datain, f);
        tick();
        chk("t2_reqin_done", reqin, 0);

        // Back-to-back burst of three
        do_reset();
        ackin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fb[i] = mk(3'd1, 3'd0, 42'd0, 16'(i + 1));
            inj_q.push_back(fb[i]);
            write_flit(fb[i]);
        end
        chk("t3_b2b_d2", datain, fb[1]);
        tick();
        chk("t3_b2b_d3", datain, fb[2]);
        chk("t3_b2b_req3", reqin, 1);
        tick();
        chk("t3_b2b_end", reqin, 0);

        // Burst with a 3-cycle ack stall after the first transfer
        ackin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fb[i] = mk(3'd1, 3'd0, 42'd0, 16'(i + 4));
            inj_q.push_back(fb[i]);
            write_flit(fb[i]);
        end
        f5 = fb[1];
        ackin = 1'b1;
        tick();
        ackin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall_req", reqin, 1);
            chk("t3_stall_data", datain, f5);
        end
        ackin = 1'b1;
        tick(); tick();
        chk("t3_stall_end", reqin, 0);

        // Overflow: nine writes into eight entries with no ack
        do_reset();
        ackin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f = mk(3'd1, 3'd0, 42'd0, 16'(16 + i));
            inj_q.push_back(f);
            write_flit(f);
            if (i == 6) chk("t4_full_7", tx_full, 0);
        end
        chk("t4_full_8", tx_full, 1);
        chk("t4_ovf_8", err_overflow, 0);
        write_flit(mk(3'd1, 3'd0, 42'd0, 16'd24));
        chk("t4_ovf_9", err_overflow, 1);
        chk("t4_full_9", tx_full, 1);
        ackin = 1'b1;
        for (int i = 0; i < 20 && reqin; i++) tick();
        chk("t4_drained", inj_q.size(), 0);
        chk("t4_full_after", tx_full, 0);
        chk("t4_ovf_sticky", err_overflow, 1);

        // Ejection at node (1,0) with host backpressure
        do_reset();
        lx = 3'd1; ly = 3'd0;
        d7 = mk(3'd1, 3'd0, 42'd0, 16'd7);
        d9 = mk(3'd1, 3'd0, 42'd0, 16'd9);
        rx_q.push_back(d7);
        rx_q.push_back(d9);
        rx_ready = 1'b0;
        reqout = 1'b1; dataout = d7;
        #1;
        chk("t5_ack_first", ackout, 1);
        tick();
        seen_exp = 64'd0;
        seen_exp[7] = 1'b1;
        chk("t5_valid1", rx_valid, 1);
        chk("t5_flit1", rx_flit, d7);
        chk("t5_seen7", rx_seen, seen_exp);
        dataout = d9;
        #1;
        chk("t5_ack_blocked", ackout, 0);
        tick();
        chk("t5_ack_blocked2", ackout, 0);
        chk("t5_flit_held", rx_flit, d7);
        rx_ready = 1'b1;
        #1;
        chk("t5_ack_ready", ackout, 1);
        tick();
        chk("t5_flit2", rx_flit, d9);
        chk("t5_valid2", rx_valid, 1);
        reqout = 1'b0; dataout = '0;
        #1;
        chk("t5_ack_idle", ackout, 0);
        tick();
        seen_exp[9] = 1'b1;
        chk("t5_valid_drop", rx_valid, 0);
        chk("t5_seen79", rx_seen, seen_exp);
        chk("t5_no_misroute", err_misroute, 0);

        // Misrouted flit at node (1,1), then reset mid-handshake
        lx = 3'd1; ly = 3'd1;
        dm = mk(3'd0, 3'd1, 42'd0, 16'd3);
        rx_q.push_back(dm);
        reqout = 1'b1; dataout = dm;
        tick();
        reqout = 1'b0; dataout = '0;
        seen_exp[3] = 1'b1;
        chk("t6_misroute", err_misroute, 1);
        chk("t6_seen", rx_seen, seen_exp);
        tick(); tick();
        chk("t6_misroute_sticky", err_misroute, 1);
        ackin = 1'b0;
        rx_ready = 1'b0;
        write_flit(mk(3'd1, 3'd1, 42'd0, 16'd40));
        tick();
        chk("t6_req_inflight", reqin, 1);
        do_reset();
        check_reset("rst1");
        ackin = 1'b1;
        tick(); tick(); tick();
        chk("t6_fifo_flushed", reqin, 0);

        chk("end_inj_q_empty", inj_q.size(), 0);
        chk("end_rx_q_empty", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
